// File: rtl/res_sel_arb.sv
// Result-select arbiter: picks one of NCH channel results (direct select or
// round-robin) into a single registered output stage with valid/ready flow control.
module res_sel_arb #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_ov,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_ov,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 ov_sticky,
  input  logic                 ov_clr
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_ov;
  logic [SELW-1:0]  r_ch;
  logic [SELW-1:0]  r_last;
  logic             r_sticky;

  logic             w_grant_vld;
  logic [SELW-1:0]  w_grant;
  logic             w_can_load;
  logic             w_xfer;
  logic [WIDTH-1:0] w_gdata;
  logic             w_gov;

  // Round-robin scans offsets from NCH down to 1 so the smallest offset
  // (closest channel after r_last) is the last assignment and wins.
  always_comb begin : p_grant
    int unsigned idx;
    idx         = 0;
    w_grant_vld = 1'b0;
    w_grant     = '0;
    if (!mode) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (sel == SELW'(k) && in_valid[k]) begin
          w_grant_vld = 1'b1;
          w_grant     = SELW'(k);
        end
      end
    end else begin
      for (int unsigned off = NCH; off >= 1; off--) begin
        idx = (32'(r_last) + off) % NCH;
        if (in_valid[SELW'(idx)]) begin
          w_grant_vld = 1'b1;
          w_grant     = SELW'(idx);
        end
      end
    end
  end

  always_comb begin : p_mux
    w_gdata = '0;
    w_gov   = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (w_grant == SELW'(k)) begin
        w_gdata = in_data[k*WIDTH +: WIDTH];
        w_gov   = in_ov[k];
      end
    end
  end

  assign w_can_load = reset_n & ((r_state == ST_EMPTY) | out_ready);
  assign w_xfer     = w_grant_vld & w_can_load;

  always_comb begin : p_ready
    in_ready = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (w_xfer && w_grant == SELW'(k)) in_ready[k] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_EMPTY;
      r_data   <= '0;
      r_ov     <= 1'b0;
      r_ch     <= '0;
      r_last   <= SELW'(NCH - 1);
      r_sticky <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_state <= ST_FULL;
        r_data  <= w_gdata;
        r_ov    <= w_gov;
        r_ch    <= w_grant;
        r_last  <= w_grant;
      end else if (r_state == ST_FULL && out_ready) begin
        r_state <= ST_EMPTY;
      end
      if (w_xfer && w_gov) r_sticky <= 1'b1;
      else if (ov_clr)     r_sticky <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_ov    = r_ov;
  assign out_ch    = r_ch;
  assign out_valid = (r_state == ST_FULL);
  assign ov_sticky = r_sticky;

endmodule

// File: tb/tb_res_sel_arb.sv
// Directed bench for res_sel_arb: expected results queued at stimulus time,
// popped and compared whenever the DUT hands a result downstream.
module tb_res_sel_arb;

  logic        clk;
  logic        reset_n;
  logic [63:0] in_data;
  logic [3:0]  in_ov;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] out_data;
  logic        out_ov;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
  logic        ov_sticky;
  logic        ov_clr;

  typedef struct packed {
    logic [15:0] d;
    logic        ov;
    logic [1:0]  ch;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  res_sel_arb #(.WIDTH(16), .NCH(4), .SELW(2)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_ov(in_ov),
    .in_valid(in_valid), .in_ready(in_ready), .mode(mode), .sel(sel),
    .out_data(out_data), .out_ov(out_ov), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready), .ov_sticky(ov_sticky),
    .ov_clr(ov_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic ov, input logic [1:0] ch);
    sb.push_back({d, ov, ch});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [15:0] v);
    in_data[k*16 +: 16] = v;
  endtask

  // A result leaves the output register on the next edge when valid and ready
  always @(negedge clk) begin
    if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL sb_extra: observed out_ch %0d out_data %0h expected no result", out_ch, out_data);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_data", 32'(out_data), 32'(mon_e.d));
        chk("sb_ov",   32'(out_ov),   32'(mon_e.ov));
        chk("sb_ch",   32'(out_ch),   32'(mon_e.ch));
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    mode      = 1'b1;
    sel       = 2'd0;
    in_valid  = 4'b1111;
    in_ov     = 4'b0000;
    out_ready = 1'b1;
    ov_clr    = 1'b0;
    in_data   = {16'hD003, 16'hD002, 16'hD001, 16'hD000};

    repeat (2) cyc();
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data),  0);
    chk("rst_out_ch",    32'(out_ch),    0);
    chk("rst_ov_sticky", 32'(ov_sticky), 0);
    chk("rst_in_ready",  32'(in_ready),  0);

    // Round-robin from reset: 0,1,2,3,0 back-to-back
    push(16'hD000, 1'b0, 2'd0);
    push(16'hD001, 1'b0, 2'd1);
    push(16'hD002, 1'b0, 2'd2);
    push(16'hD003, 1'b0, 2'd3);
    push(16'hD000, 1'b0, 2'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("rr_in_ready", 32'(in_ready), 32'(1) << (i % 4));
      cyc();
    end
    in_valid = 4'b0000;
    cyc();
    chk("rr_drain_valid", 32'(out_valid), 0);
    chk("rr_sticky",      32'(ov_sticky), 0);

    // Direct select with overflow
    mode     = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b0100;
    in_ov    = 4'b0100;
    set_ch(2, 16'h1234);
    push(16'h1234, 1'b1, 2'd2);
    #1 chk("sel2_in_ready", 32'(in_ready), 32'h4);
    cyc();
    chk("sel2_out_valid", 32'(out_valid), 1);
    chk("sel2_sticky",    32'(ov_sticky), 1);
    in_valid = 4'b0000;
    in_ov    = 4'b0000;
    cyc();

    // Selected channel not valid: no grant
    sel      = 2'd1;
    in_valid = 4'b1101;
    #1 chk("nogrant_in_ready", 32'(in_ready), 0);
    cyc();
    chk("nogrant_out_valid", 32'(out_valid), 0);
    in_valid = 4'b0000;

    // Sticky: set wins over simultaneous clear, then clear alone
    sel      = 2'd0;
    in_valid = 4'b0001;
    in_ov    = 4'b0001;
    set_ch(0, 16'h0BEE);
    ov_clr   = 1'b1;
    push(16'h0BEE, 1'b1, 2'd0);
    cyc();
    chk("sticky_set_wins", 32'(ov_sticky), 1);
    in_valid = 4'b0000;
    in_ov    = 4'b0000;
    cyc();
    chk("sticky_cleared", 32'(ov_sticky), 0);
    ov_clr = 1'b0;

    // Backpressure hold
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    set_ch(0, 16'hAAAA);
    push(16'hAAAA, 1'b0, 2'd0);
    cyc();
    sel      = 2'd1;
    in_valid = 4'b0010;
    set_ch(1, 16'h5555);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_data",     32'(out_data),  32'hAAAA);
      chk("hold_in_ready", 32'(in_ready),  0);
      chk("hold_valid",    32'(out_valid), 1);
      cyc();
    end
    push(16'h5555, 1'b0, 2'd1);
    out_ready = 1'b1;
    #1 chk("release_in_ready", 32'(in_ready), 32'h2);
    cyc();
    in_valid = 4'b0000;
    chk("release_ch",   32'(out_ch),   1);
    chk("release_data", 32'(out_data), 32'h5555);
    cyc();

    // Async reset while FULL, then round-robin restarts at channel 0
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    set_ch(1, 16'h7777);
    cyc();
    in_valid = 4'b0000;
    #2 reset_n = 1'b0;
    mode     = 1'b1;
    in_valid = 4'b1111;
    in_data  = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_data",  32'(out_data),  0);
    chk("arst_out_ch",    32'(out_ch),    0);
    chk("arst_in_ready",  32'(in_ready),  0);
    out_ready = 1'b1;
    push(16'hD000, 1'b0, 2'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc();
    in_valid = 4'b0000;
    chk("arst_first_ch", 32'(out_ch), 0);
    cyc();

    // Round-robin skips idle channels
    in_valid = 4'b1010;
    push(16'hD001, 1'b0, 2'd1);
    push(16'hD003, 1'b0, 2'd3);
    push(16'hD001, 1'b0, 2'd1);
    repeat (3) cyc();
    in_valid = 4'b0000;
    repeat (3) cyc();

    chk("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/res_sel_arb.md
RES_SEL_ARB -- requirements
Module: res_sel_arb

Interface
REQ-001 Parameter WIDTH, default 16: result data width per channel.
REQ-002 Parameter NCH, default 4: number of input channels, range 2..16.
REQ-003 Parameter SELW, default 2: select/channel-index width, equal to ceil(log2(NCH)).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_data  input  NCH*WIDTH  channel k result at bits [k*WIDTH +: WIDTH].
REQ-007 in_ov  input  NCH  channel k overflow flag, qualified by in_valid[k].
REQ-008 in_valid  input  NCH  channel k offers a result.
REQ-009 in_ready  output  NCH  channel k result accepted this cycle when in_valid[k] is also high.
REQ-010 mode  input  1  0 = direct select by sel; 1 = round-robin arbitration.
REQ-011 sel  input  SELW  channel index used in mode 0.
REQ-012 out_data  output  WIDTH  registered selected result.
REQ-013 out_ov  output  1  registered overflow flag of out_data.
REQ-014 out_ch  output  SELW  index of the channel that supplied out_data.
REQ-015 out_valid  output  1  output register holds a result.
REQ-016 out_ready  input  1  downstream accepts the output this cycle.
REQ-017 ov_sticky  output  1  set by any accepted result with overflow.
REQ-018 ov_clr  input  1  synchronous clear of ov_sticky.

Function
REQ-019 Output register SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-020 can_load = EMPTY, or FULL with out_ready=1.
REQ-021 Mode 0: grant = sel, only when sel < NCH and in_valid[sel]=1; otherwise no grant.
REQ-022 Mode 1: grant = first k with in_valid[k]=1, searching from (last_grant+1) mod NCH upward with wrap-around.
REQ-023 in_ready[grant]=can_load; all other in_ready bits SHALL be 0; with no grant, all in_ready=0.
REQ-024 Transfer = in_valid[grant] & in_ready[grant]; on a transfer the register loads in_data, in_ov and grant and is FULL next cycle (latency 1 clock).
REQ-025 FULL with out_ready=1 and no transfer -> EMPTY next cycle; FULL with out_ready=1 and a transfer -> stays FULL with new contents (back-to-back, one result per clock).
REQ-026 FULL with out_ready=0: out_data, out_ov, out_ch held stable; all in_ready=0.
REQ-027 last_grant SHALL update to grant on every transfer, in either mode; no update without a transfer.
REQ-028 A change of mode or sel SHALL affect only the next grant; a held output is not altered.
REQ-029 ov_sticky set on any transfer with in_ov[grant]=1; ov_clr=1 clears it; set and clear in the same cycle -> set wins.
REQ-030 Combinational paths: in_ready depends on in_valid, mode, sel, out_ready and state; no path from in_data to any output.

Reset
REQ-031 reset_n=0 SHALL immediately force: out_valid=0, out_data=0, out_ov=0, out_ch=0, ov_sticky=0, last_grant=NCH-1 (first round-robin search starts at channel 0).
REQ-032 Reset mid-operation SHALL discard any held result; no transfer is reported while reset_n=0 (in_ready all 0).
REQ-033 Deassertion SHALL be followed by normal operation from the first rising edge with reset_n=1.

Verification (WIDTH=16, NCH=4)
REQ-034 mode=0, sel=2, in_valid=4'b0100, in_data ch2=16'h1234, in_ov[2]=1, out_ready=1 -> next cycle out_valid=1, out_data=16'h1234, out_ch=2, out_ov=1, ov_sticky=1.
REQ-035 mode=1, in_valid=4'b1111 held, out_ready=1 from reset -> out_ch sequence 0,1,2,3,0 on consecutive cycles, one result per clock.
REQ-036 FULL with out_data=16'hAAAA, out_ready=0 for 3 cycles while ch1 offers 16'h5555 -> out_data stays 16'hAAAA, in_ready=0; out_ready=1 -> 16'h5555 appears the following cycle.
REQ-037 mode=0, sel=1, in_valid=4'b1101 -> in_ready=0000, out_valid stays 0.
REQ-038 ov_sticky=1; apply ov_clr=1 together with a transfer carrying in_ov=1 -> ov_sticky remains 1; ov_clr=1 alone the next cycle -> 0.
REQ-039 FULL state, pull reset_n low between clock edges -> out_valid=0 and out_data=0 before the next edge; first round-robin grant after release is channel 0.
